// File: rtl/branch_fwd_scoreboard_if.sv
// Branch forwarding scoreboard bus.
// Carries the ID-stage instruction fields into the scoreboard and returns
// the per-source forwarding selects, the stall request and the stall counter.
//   master : ID-stage side; drives the instruction fields, receives the results
//   slave  : scoreboard side
interface branch_fwd_scoreboard_if #(
  parameter int NUM_SRC = 2,
  parameter int REG_AW  = 5,
  parameter int DEPTH   = 3,
  parameter int CNT_W   = 16
);
  localparam int SELW = $clog2(DEPTH + 1);

  logic                      id_valid;
  logic                      id_is_branch;
  logic [NUM_SRC*REG_AW-1:0] id_src;
  logic [NUM_SRC-1:0]        id_src_used;
  logic [REG_AW-1:0]         id_dst;
  logic                      id_wen;
  logic                      id_is_load;
  logic                      flush;
  logic [NUM_SRC*SELW-1:0]   fwd_sel;
  logic                      stall;
  logic [CNT_W-1:0]          stall_cnt;

  modport master (
    output id_valid, id_is_branch, id_src, id_src_used, id_dst, id_wen,
           id_is_load, flush,
    input  fwd_sel, stall, stall_cnt
  );

  modport slave (
    input  id_valid, id_is_branch, id_src, id_src_used, id_dst, id_wen,
           id_is_load, flush,
    output fwd_sel, stall, stall_cnt
  );
endinterface

// File: rtl/branch_fwd_scoreboard.sv
// Branch operand forwarding scoreboard for an ID-stage branch unit.
// A shift register of in-flight destination writes (slot 1 = EX .. slot
// DEPTH) is searched for each branch source. The youngest producer picks the
// forwarding slot, or stalls ID when its result is not yet forwardable.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : slave side of branch_fwd_scoreboard_if (ID fields in,
//           fwd_sel / stall / stall_cnt out)
module branch_fwd_scoreboard #(
  parameter int NUM_SRC     = 2,
  parameter int REG_AW      = 5,
  parameter int DEPTH       = 3,
  parameter int ALU_STAGE   = 2,
  parameter int LOAD_STAGE  = 3,
  parameter bit ZERO_REG_EN = 1'b1,
  parameter int CNT_W       = 16
) (
  input logic                   clk,
  input logic                   rst_n,
  branch_fwd_scoreboard_if.slave bus
);
  localparam int SELW = $clog2(DEPTH + 1);

  logic [DEPTH:1]    v_q, v_d;
  logic [DEPTH:1]    wen_q, wen_d;
  logic [DEPTH:1]    ld_q, ld_d;
  logic [REG_AW-1:0] dst_q [DEPTH:1];
  logic [REG_AW-1:0] dst_d [DEPTH:1];
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [NUM_SRC-1:0]      hit;
  logic [NUM_SRC-1:0]      hit_rdy;
  logic [SELW-1:0]         hit_k [NUM_SRC];
  logic [REG_AW-1:0]       src   [NUM_SRC];
  logic [NUM_SRC*SELW-1:0] sel;
  logic                    any_not_rdy;
  logic                    stall;
  logic                    issue;

  // Youngest-producer search: scan from the oldest slot towards slot 1 so
  // the last hit written is the youngest one.
  always_comb begin
    sel         = '0;
    any_not_rdy = 1'b0;
    for (int j = 0; j < NUM_SRC; j++) begin
      src[j]     = bus.id_src[j*REG_AW +: REG_AW];
      hit[j]     = 1'b0;
      hit_rdy[j] = 1'b0;
      hit_k[j]   = '0;
      for (int k = DEPTH; k >= 1; k--) begin
        if (v_q[k] && wen_q[k] && (dst_q[k] == src[j]) && bus.id_src_used[j] &&
            !(ZERO_REG_EN && (src[j] == '0))) begin
          hit[j]     = 1'b1;
          hit_k[j]   = SELW'(k);
          hit_rdy[j] = (k >= (ld_q[k] ? LOAD_STAGE : ALU_STAGE));
        end
      end
      if (bus.id_valid && bus.id_is_branch && hit[j]) begin
        if (hit_rdy[j]) sel[j*SELW +: SELW] = hit_k[j];
        else            any_not_rdy = 1'b1;
      end
    end
    stall = bus.id_valid & bus.id_is_branch & ~bus.flush & any_not_rdy;
  end

  assign issue = bus.id_valid & ~stall & ~bus.flush;

  always_comb begin
    v_d      = v_q;
    wen_d    = wen_q;
    ld_d     = ld_q;
    dst_d    = dst_q;
    v_d[1]   = issue;
    wen_d[1] = bus.id_wen;
    ld_d[1]  = bus.id_is_load;
    dst_d[1] = bus.id_dst;
    for (int k = 2; k <= DEPTH; k++) begin
      v_d[k]   = v_q[k-1];
      wen_d[k] = wen_q[k-1];
      ld_d[k]  = ld_q[k-1];
      dst_d[k] = dst_q[k-1];
    end
    cnt_d = cnt_q;
    if (stall && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q   <= '0;
      wen_q <= '0;
      ld_q  <= '0;
      cnt_q <= '0;
      for (int k = 1; k <= DEPTH; k++) dst_q[k] <= '0;
    end else begin
      v_q   <= v_d;
      wen_q <= wen_d;
      ld_q  <= ld_d;
      cnt_q <= cnt_d;
      for (int k = 1; k <= DEPTH; k++) dst_q[k] <= dst_d[k];
    end
  end

  assign bus.fwd_sel   = sel;
  assign bus.stall     = stall;
  assign bus.stall_cnt = cnt_q;
endmodule
